// File: rtl/md5_pkg.sv
// md5_pkg: shared types, constants and helpers for the MD5 message padder.
//   pad_state_t : padder FSM states
//   pad_word_t  : output word payload (data + block/message flags)
//   pad_merge() : builds the final partial word with the 0x80 marker
package md5_pkg;

    localparam int unsigned MD5_DATA_W        = 32;
    localparam int unsigned MD5_NB_W          = 3;
    localparam int unsigned MD5_WIDX_W        = 4;
    localparam int unsigned MD5_CNT_W         = 61;
    localparam int unsigned MD5_LEN_W         = 64;
    localparam int unsigned MD5_WORDS_PER_BLK = 16;

    localparam logic [MD5_WIDX_W-1:0] MD5_LEN_WIDX  = 4'd14;
    localparam logic [MD5_WIDX_W-1:0] MD5_LAST_WIDX = 4'(MD5_WORDS_PER_BLK - 1);
    localparam logic [7:0]            MD5_PAD_BYTE  = 8'h80;

    typedef enum logic [2:0] {
        PASS,
        PAD80,
        ZERO,
        LEN0,
        LEN1
    } pad_state_t;

    typedef struct packed {
        logic [MD5_DATA_W-1:0] data;
        logic                  blk_last;
        logic                  msg_last;
    } pad_word_t;

    // Keep bytes below nbytes, place the marker at byte nbytes, zero the rest.
    // nbytes == 4 returns the word unchanged.
    function automatic logic [MD5_DATA_W-1:0] pad_merge(
        input logic [MD5_DATA_W-1:0] data,
        input logic [MD5_NB_W-1:0]   nbytes
    );
        logic [MD5_DATA_W-1:0] r;
        r = data;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) == nbytes) begin
                r[8*i +: 8] = MD5_PAD_BYTE;
            end else if (3'(i) > nbytes) begin
                r[8*i +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/md5_msg_padder.sv
// md5_msg_padder: streaming RFC 1321 message padder feeding the MD5 core.
// Accepts little-endian 32-bit message words and emits 512-bit blocks as
// 16 serialized words with marker, zero fill and 64-bit bit length.
// Ports:
//   ACLK, ARESETN            clock, async active-low reset
//   s_data/s_nbytes/s_last   input word, valid byte count, end of message
//   s_valid/s_ready          input handshake
//   m_data/m_valid/m_ready   output word handshake (one registered stage)
//   m_blk_last/m_msg_last    word 15 of a block / of the final block
//   err                      sticky protocol error
//   blk_cnt                  completed block count (MD5_PAD_BLOCK_CNT_EN only)
// Optional feature macro: MD5_PAD_BLOCK_CNT_EN
module md5_msg_padder
    import md5_pkg::*;
(
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [MD5_DATA_W-1:0] s_data,
    input  logic [MD5_NB_W-1:0]   s_nbytes,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [MD5_DATA_W-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_blk_last,
    output logic                  m_msg_last,
    output logic                  err
`ifdef MD5_PAD_BLOCK_CNT_EN
    ,
    output logic [31:0]           blk_cnt
`endif
);

    pad_state_t              state;
    pad_state_t              state_nxt;
    logic [MD5_WIDX_W-1:0]   widx;
    logic [MD5_CNT_W-1:0]    byte_cnt;
    logic [MD5_LEN_W-1:0]    bit_len;
    pad_word_t               out_q;
    pad_word_t               emit_word;
    logic                    load_en;
    logic                    emit;
    logic                    in_fire;
    logic                    cnt_clr;
    logic                    err_set;
    logic                    bad;
    logic                    eff_last;
    logic [MD5_NB_W-1:0]     nb_clamp;
    pad_state_t              fill_nxt;

    assign bit_len    = {byte_cnt, 3'b000};
    assign load_en    = !m_valid || m_ready;
    // Reset gates s_ready so nothing looks acceptable while ARESETN is low.
    assign s_ready    = ARESETN && (state == PASS) && load_en;
    assign m_data     = out_q.data;
    assign m_blk_last = out_q.blk_last;
    assign m_msg_last = out_q.msg_last;

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= PASS;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the word to load into the output register
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_word = '0;
        in_fire   = 1'b0;
        cnt_clr   = 1'b0;
        err_set   = 1'b0;
        bad       = ((s_nbytes < 3'd4) && !s_last) || (s_nbytes > 3'd4);
        eff_last  = s_last || bad;
        nb_clamp  = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
        // After emitting the word at widx, length goes next only if widx+1 is 14.
        fill_nxt  = (4'(widx + 4'd1) == MD5_LEN_WIDX) ? LEN0 : ZERO;

        case (state)
            PASS: begin
                if (s_valid && s_ready) begin
                    in_fire        = 1'b1;
                    emit           = 1'b1;
                    err_set        = bad;
                    emit_word.data = s_data;
                    if (eff_last && (nb_clamp < 3'd4)) begin
                        emit_word.data = pad_merge(s_data, nb_clamp);
                        state_nxt      = fill_nxt;
                    end else if (eff_last) begin
                        state_nxt      = PAD80;
                    end
                end
            end
            PAD80: begin
                if (load_en) begin
                    emit           = 1'b1;
                    emit_word.data = {24'h0, MD5_PAD_BYTE};
                    state_nxt      = fill_nxt;
                end
            end
            ZERO: begin
                if (load_en) begin
                    emit      = 1'b1;
                    state_nxt = fill_nxt;
                end
            end
            LEN0: begin
                if (load_en) begin
                    emit           = 1'b1;
                    emit_word.data = bit_len[31:0];
                    state_nxt      = LEN1;
                end
            end
            LEN1: begin
                if (load_en) begin
                    emit               = 1'b1;
                    emit_word.data     = bit_len[63:32];
                    emit_word.msg_last = 1'b1;
                    cnt_clr            = 1'b1;
                    state_nxt          = PASS;
                end
            end
            default: state_nxt = PASS;
        endcase

        emit_word.blk_last = (widx == MD5_LAST_WIDX);
    end

    // Output register, word index, byte counter and sticky error
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_q    <= '0;
            m_valid  <= 1'b0;
            widx     <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (load_en) begin
                m_valid <= emit;
                if (emit) begin
                    out_q <= emit_word;
                    widx  <= cnt_clr ? '0 : 4'(widx + 4'd1);
                end
            end
            if (cnt_clr) begin
                byte_cnt <= '0;
            end else if (in_fire) begin
                byte_cnt <= byte_cnt + 61'(nb_clamp);
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

`ifdef MD5_PAD_BLOCK_CNT_EN
    // Completed-block counter, bumped on each m_blk_last transfer
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            blk_cnt <= '0;
        end else if (m_valid && m_ready && m_blk_last) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule
